keypad_scanner: RTL and testbench

- Drives a 4x4 matrix keypad, one active-low row strobe at a time, and reads the four active-low column returns.
- Debounces each full-matrix scan result over consecutive scans.
- Reports each accepted key press as a code on a valid/ack handshake, plus a level key_down flag.
- Sits between board keypad pins and the game control logic; it is the output-driving counterpart of the single-button input filter.

---
 rtl/keypad_scanner.sv | 137 +++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one row low at a time, debounces whole-matrix
// scan results and reports accepted presses on a valid/ack handshake.
module keypad_scanner #(
  parameter int DWELL      = 1000,
  parameter int HOLD_SCANS = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = $clog2(HOLD_SCANS + 1);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_kind_t;

  logic [CW-1:0] dwell_cnt, dwell_next;
  logic [1:0]    row_idx, row_next;
  logic [3:0]    col_meta, col_sync;
  logic [15:0]   acc;
  logic          sample_now, eval_pending;

  res_kind_t     res_kind, prev_kind, acc_kind;
  logic [3:0]    res_code, prev_code, acc_code;
  logic [4:0]    low_count;
  logic [SW-1:0] stable_cnt, stable_next;
  logic          same, saturated, accept, press_event;

  always_comb begin
    sample_now = (dwell_cnt == CW'(DWELL - 1));
    dwell_next = sample_now ? '0 : dwell_cnt + CW'(1);
    row_next   = sample_now ? row_idx + 2'd1 : row_idx;
  end

  // The accumulator holds active-low column samples, bit index = row*4 + col.
  always_ff @(posedge clock) begin
    if (reset) begin
      dwell_cnt    <= '0;
      row_idx      <= 2'd0;
      row_n        <= 4'b1110;
      col_meta     <= 4'hF;
      col_sync     <= 4'hF;
      acc          <= '1;
      eval_pending <= 1'b0;
    end else begin
      col_meta     <= col_n;
      col_sync     <= col_meta;
      dwell_cnt    <= dwell_next;
      row_idx      <= row_next;
      row_n        <= ~(4'b0001 << row_next);
      if (sample_now) begin
        acc[{row_idx, 2'b00} +: 4] <= col_sync;
      end
      eval_pending <= sample_now && (row_idx == 2'd3);
    end
  end

  always_comb begin
    low_count = '0;
    res_code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (!acc[i]) begin
        low_count = low_count + 5'd1;
        res_code  = 4'(i);
      end
    end
    if (low_count == 5'd0) begin
      res_kind = RES_NONE;
    end else if (low_count == 5'd1) begin
      res_kind = RES_SINGLE;
    end else begin
      res_kind = RES_MULTI;
    end
    if (res_kind != RES_SINGLE) begin
      res_code = '0;
    end
  end

  // Acceptance fires only on the scan that brings the run length up to HOLD_SCANS.
  always_comb begin
    same        = (res_kind == prev_kind) && (res_code == prev_code);
    saturated   = (stable_cnt == SW'(HOLD_SCANS));
    stable_next = !same ? SW'(1) : (saturated ? stable_cnt : stable_cnt + SW'(1));
    accept      = eval_pending && (stable_next == SW'(HOLD_SCANS)) && !(same && saturated);
    press_event = accept && (res_kind == RES_SINGLE) &&
                  !((acc_kind == RES_SINGLE) && (acc_code == res_code));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_kind  <= RES_NONE;
      prev_code  <= '0;
      stable_cnt <= '0;
      acc_kind   <= RES_NONE;
      acc_code   <= '0;
      key_down   <= 1'b0;
    end else if (eval_pending) begin
      prev_kind  <= res_kind;
      prev_code  <= res_code;
      stable_cnt <= stable_next;
      if (press_event) begin
        acc_kind <= RES_SINGLE;
        acc_code <= res_code;
        key_down <= 1'b1;
      end else if (accept && (res_kind == RES_NONE)) begin
        acc_kind <= RES_NONE;
        acc_code <= '0;
        key_down <= 1'b0;
      end
    end
  end

  // A press arriving while an event is still pending is dropped unless acked this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (press_event) begin
      if (!key_valid || key_ack) begin
        key_code  <= res_code;
        key_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios with literal expectations,
// then random key patterns, all compared every cycle against a behavioural keypad model.
module tb_keypad_scanner;

  localparam int DWELL      = 4;
  localparam int HOLD_SCANS = 3;
  localparam int SCAN       = 4 * DWELL;
  localparam int RES_NONE   = -1;
  localparam int RES_MULTI  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_down;
  logic        overrun;
  logic [15:0] keys = 16'h0000;

  int vectors     = 0;
  int miscompares = 0;

  keypad_scanner #(.DWELL(DWELL), .HOLD_SCANS(HOLD_SCANS)) dut (
    .clock    (clock),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_down (key_down),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its column to whichever row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [15:0] k, input logic a);
    keys    = k;
    key_ack = a;
    advance(1);
  endtask

  task automatic doReset(input logic [15:0] k);
    @(posedge clock);
    #2;
    keys    = k;
    key_ack = 1'b0;
    reset   = 1'b1;
    advance(1);
    reset   = 1'b0;
  endtask

  // Behavioural model: cycle index since reset, the key state the scanner sees per row,
  // run length of identical scan results and the handshake outputs.
  bit          model_ok = 0;
  int          mcyc, prev_res, run_len, acc_res, res, hits, idx, mrow;
  logic [15:0] seen;
  logic        m_valid, m_down, m_over, ev;
  logic [3:0]  m_code, ev_code, exp_row;

  always @(negedge clock) begin
    if (model_ok) begin
      exp_row = 4'b1111;
      exp_row[(mcyc / DWELL) % 4] = 1'b0;
      checkOutput("row_n", row_n, exp_row);
      checkOutput("key_valid", key_valid, m_valid);
      checkOutput("key_code", key_code, m_code);
      checkOutput("key_down", key_down, m_down);
      checkOutput("overrun", overrun, m_over);
    end
    if (reset) begin
      model_ok = 1;
      mcyc = 0; seen = '0; prev_res = RES_NONE; run_len = 0; acc_res = RES_NONE;
      m_valid = 0; m_down = 0; m_over = 0; m_code = '0;
    end else if (model_ok) begin
      ev = 0;
      ev_code = '0;
      if (mcyc > 0 && (mcyc % SCAN) == 0) begin
        hits = $countones(seen);
        idx = 0;
        for (int i = 0; i < 16; i++) if (seen[i]) idx = i;
        res = (hits == 0) ? RES_NONE : (hits == 1) ? idx : RES_MULTI;
        run_len = (res == prev_res) ? run_len + 1 : 1;
        prev_res = res;
        if (run_len == HOLD_SCANS) begin
          if (res == RES_NONE) begin
            acc_res = RES_NONE;
            m_down = 0;
          end else if (res != RES_MULTI && res != acc_res) begin
            acc_res = res;
            m_down = 1;
            ev = 1;
            ev_code = 4'(res);
          end
        end
      end
      // Two synchronizer stages mean the sample at the end of a row reflects keys DWELL-3 cycles in.
      if ((mcyc % DWELL) == DWELL - 3) begin
        mrow = (mcyc / DWELL) % 4;
        seen[mrow*4 +: 4] = keys[mrow*4 +: 4];
      end
      if (ev) begin
        if (!m_valid || key_ack) begin
          m_valid = 1;
          m_code = ev_code;
        end else begin
          m_over = 1;
        end
      end else if (m_valid && key_ack) begin
        m_valid = 0;
      end
      mcyc++;
    end
  end

  logic [15:0] one = 16'h0001;
  logic [15:0] pat;
  int          kind, len, ka, kb;

  initial begin
    // Idle keypad: reset values, row rotation, no events.
    doReset(16'h0000);
    checkOutput("a_row0", row_n, 4'b1110);
    checkOutput("a_valid0", key_valid, 1'b0);
    checkOutput("a_code0", key_code, 4'h0);
    checkOutput("a_down0", key_down, 1'b0);
    checkOutput("a_over0", overrun, 1'b0);
    advance(4);
    checkOutput("a_row4", row_n, 4'b1101);
    advance(76);
    checkOutput("a_valid80", key_valid, 1'b0);

    // Key 9 (row 2, col 1) held from reset: event after the third scan.
    doReset(16'h0200);
    advance(48);
    checkOutput("b_valid48", key_valid, 1'b0);
    advance(1);
    checkOutput("b_valid49", key_valid, 1'b1);
    checkOutput("b_code49", key_code, 4'd9);
    checkOutput("b_down49", key_down, 1'b1);
    applyStimulus(16'h0200, 1'b1);
    key_ack = 1'b0;
    checkOutput("b_ack50", key_valid, 1'b0);
    advance(10 * SCAN);
    checkOutput("b_noreevent", key_valid, 1'b0);
    checkOutput("b_stilldown", key_down, 1'b1);

    // Overrun: press 3 unacked, release, press 12, then 7 lands with an ack.
    doReset(16'h0008);
    advance(49);
    checkOutput("c_code3", key_code, 4'd3);
    keys = 16'h0000;
    advance(48);
    checkOutput("c_release", key_down, 1'b0);
    checkOutput("c_pending", key_valid, 1'b1);
    keys = 16'h1000;
    advance(48);
    checkOutput("c_over", overrun, 1'b1);
    checkOutput("c_keep3", key_code, 4'd3);
    keys = 16'h0080;
    advance(47);
    key_ack = 1'b1;
    advance(1);
    key_ack = 1'b0;
    checkOutput("c_valid7", key_valid, 1'b1);
    checkOutput("c_code7", key_code, 4'd7);
    checkOutput("c_oversticky", overrun, 1'b1);

    // Mid-scan reset while an event is pending, then fresh detection.
    advance(7);
    checkOutput("d_prevalid", key_valid, 1'b1);
    doReset(16'h0080);
    checkOutput("d_row", row_n, 4'b1110);
    checkOutput("d_valid", key_valid, 1'b0);
    checkOutput("d_code", key_code, 4'h0);
    checkOutput("d_over", overrun, 1'b0);
    checkOutput("d_down", key_down, 1'b0);
    advance(49);
    checkOutput("d_fresh", key_valid, 1'b1);
    checkOutput("d_freshcode", key_code, 4'd7);

    // Random segments: idle, single key, two keys (ghosting) and chatter.
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(16, 160);
      ka   = $urandom_range(0, 15);
      kb   = (ka + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       pat = 16'h0000;
        2:       pat = (one << ka) | (one << kb);
        default: pat = one << ka;
      endcase
      if (seg == 30) doReset(pat);
      for (int c = 0; c < len; c++) begin
        applyStimulus((kind == 3 && ((c / 20) % 2) == 1) ? 16'h0000 : pat,
                      $urandom_range(0, 7) == 0);
      end
    end

    applyStimulus(16'h0000, 1'b1);
    advance(4 * SCAN);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
